dtc_edge_gen: RTL and testbench
===============================

DTC_EDGE_GEN -- requirements
Module: dtc_edge_gen

Interface
REQ-001 Parameter COARSE_W, default 8, coarse delay field width in dco_clk cycles.
REQ-002 Parameter FINE_W, default 2, fine delay-line tap select width.
REQ-003 dco_clk  input  1  sole clock; all logic samples on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 code  input  COARSE_W+FINE_W (10)  delay code {coarse[7:0], fine[1:0]}, same packing as the TDC phase_error word.
REQ-006 code_valid  input  1  code is presented this cycle.
REQ-007 code_ready  output  1  queue slot free; code is accepted when code_valid and code_ready are both high.
REQ-008 trig  input  1  single-cycle start pulse (ref edge, already synchronised to dco_clk).
REQ-009 edge_out  output  1  one-cycle delayed edge pulse.
REQ-010 fine_sel  output  FINE_W  tap select for the external delay line; equals the fine field while edge_out is high, else 0.
REQ-011 busy  output  1  high in COUNT and FIRE.
REQ-012 overrun  output  1  sticky; set by a trig received in COUNT or FIRE.
REQ-013 miss  output  1  sticky; set by a trig received in IDLE.
REQ-014 err_clr  input  1  clears overrun and miss; a same-cycle set wins.

Function
REQ-015 The block shall hold two code registers: active (drives the timing) and next (one-entry queue); code_ready = next empty.
REQ-016 States: IDLE (no active code), ARMED (active code, waiting for trig), COUNT (cycle countdown), FIRE (edge_out high for exactly one cycle).
REQ-017 IDLE: an accepted code goes directly to active, with a transition to ARMED; next stays empty.
REQ-018 ARMED: a code accepted while next is empty goes into next; active is unchanged.
REQ-019 ARMED with trig: load cnt = coarse; go to FIRE if coarse = 0, else to COUNT.
REQ-020 COUNT: decrement cnt each cycle; go to FIRE in the cycle cnt = 1.
REQ-021 Latency: with trig sampled in cycle T, edge_out is high in cycle T+coarse+1 (range 1..256).
REQ-022 FIRE exit: if next is full, move next to active (freeing next) and go to ARMED; otherwise go to IDLE (see REQ-031).
REQ-023 A code may be accepted in any state while next is empty, including FIRE; a code accepted in FIRE moves to active on the same exit edge.
REQ-024 Same-cycle code accept and trig in IDLE: capture the code, ignore the trig, and set miss.
REQ-025 A trig received in COUNT or FIRE shall not restart the countdown; it sets overrun.
REQ-026 No arithmetic wrap: cnt never decrements below 1 in COUNT.

Reset
REQ-027 Reset shall force state = IDLE, cnt = 0, next empty, active = 0.
REQ-028 Reset shall force edge_out = 0, fine_sel = 0, busy = 0, overrun = 0, miss = 0, and code_ready = 1 in the following cycle.
REQ-029 Reset asserted mid-COUNT shall abort the countdown with no edge_out pulse, and code_valid during reset shall be ignored.

Configuration
REQ-030 Macro DTC_AUTORELOAD_EN selects the FIRE-exit behaviour when next is empty.
REQ-031 Defined: FIRE exit with next empty goes to ARMED and retains the active code, so repeated trigs reuse the last code.
REQ-032 Undefined: FIRE exit with next empty goes to IDLE (code consumed).
REQ-033 REQ-022 (next full takes priority) shall hold in both configurations.

Structure
REQ-034 Package dtc_pkg shall hold the state enum, COARSE_W, FINE_W, CODE_W, and field-extract helpers for {coarse, fine}.
REQ-035 Sub-module dtc_code_buf shall implement the one-entry next register with its valid/ready handshake; the FSM and counter stay in dtc_edge_gen.

Verification
REQ-036 Reset release, then load code 10'h008 (coarse 2, fine 0), trig at cycle T -> edge_out high only at T+3, fine_sel = 0, then back to IDLE.
REQ-037 Load code {coarse 0, fine 3}, then trig -> edge_out and fine_sel = 3 in the cycle after trig; fine_sel = 0 otherwise.
REQ-038 Load {5,1}, trig, queue {1,2} during COUNT, then trig in COUNT -> overrun = 1.
  - Edge at T+6 with fine_sel = 1, then ARMED with {1,2}.
  - Next trig gives an edge 2 cycles later with fine_sel = 2.
REQ-039 Trig in IDLE -> miss = 1, no edge.
  - err_clr -> miss = 0.
  - Code accept plus trig in the same IDLE cycle -> ARMED, miss = 1.
REQ-040 Queue full (active plus next loaded) -> code_ready = 0 and the third code is held off until FIRE exit.
REQ-041 Reset two cycles into a coarse = 200 countdown -> no edge_out pulse, all outputs at reset values.
REQ-042 With DTC_AUTORELOAD_EN: one code, three trigs spaced 20 cycles -> three edges at identical offsets.
REQ-043 Without DTC_AUTORELOAD_EN: same stimulus -> one edge, then miss = 1.

Source files
------------

// File: rtl/dtc_pkg.sv
// Shared state type, code widths and {coarse, fine} field helpers for the DTC edge generator.
package dtc_pkg;
   localparam int COARSE_W = 8;
   localparam int FINE_W   = 2;
   localparam int CODE_W   = COARSE_W + FINE_W;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_COUNT,
      ST_FIRE
   } dtc_state_t;

   function automatic logic [COARSE_W-1:0] code_coarse(input logic [CODE_W-1:0] code);
      return code[CODE_W-1:FINE_W];
   endfunction

   function automatic logic [FINE_W-1:0] code_fine(input logic [CODE_W-1:0] code);
      return code[FINE_W-1:0];
   endfunction
endpackage

// File: rtl/dtc_code_buf.sv
// One-entry holding register for the next delay code.
// Latency: push visible as q_vld one cycle after the accepting edge.
// Backpressure: push_rdy low while the entry is full or reset is asserted.
module dtc_code_buf #(
   parameter int W = 10
) (
   input  logic         dco_clk,
   input  logic         reset,
   input  logic         push_vld,
   output logic         push_rdy,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic         q_vld,
   output logic [W-1:0] q_dat
);
   assign push_rdy = ~q_vld & ~reset;

   always_ff @(posedge dco_clk) begin
      if (reset) begin
         q_vld <= 1'b0;
         q_dat <= '0;
      end else if (push_vld && push_rdy) begin
         q_vld <= 1'b1;
         q_dat <= push_dat;
      end else if (pop) begin
         q_vld <= 1'b0;
      end
   end
endmodule

// File: rtl/dtc_edge_gen.sv
// Delayed edge generator: trig -> edge_out after coarse+1 cycles, with fine tap select. Macro DTC_AUTORELOAD_EN keeps the code after firing.
// Latency: edge_out high in cycle T+coarse+1 for a trig sampled in cycle T.
// Backpressure: code_ready low while the next-code slot is occupied.
module dtc_edge_gen #(
   parameter int COARSE_W = 8,
   parameter int FINE_W   = 2
) (
   input  logic                       dco_clk,
   input  logic                       reset,
   input  logic [COARSE_W+FINE_W-1:0] code,
   input  logic                       code_valid,
   output logic                       code_ready,
   input  logic                       trig,
   output logic                       edge_out,
   output logic [FINE_W-1:0]          fine_sel,
   output logic                       busy,
   output logic                       overrun,
   output logic                       miss,
   input  logic                       err_clr
);
   import dtc_pkg::*;

   localparam int CW = COARSE_W + FINE_W;

   dtc_state_t          state;
   logic [COARSE_W-1:0] cnt;
   logic [CW-1:0]       act_dat;
   logic [CW-1:0]       nxt_dat;
   logic                nxt_vld;
   logic                code_acc;
   logic                buf_push;
   logic                buf_pop;
   logic [COARSE_W-1:0] act_coarse;
   logic [FINE_W-1:0]   act_fine;

   assign act_coarse = act_dat[CW-1:FINE_W];
   assign act_fine   = act_dat[FINE_W-1:0];
   assign code_acc   = code_valid & code_ready;
   // Codes arriving in IDLE or FIRE bypass the queue and land straight in active.
   assign buf_push   = code_valid & ((state == ST_ARMED) | (state == ST_COUNT));
   assign buf_pop    = (state == ST_FIRE) & nxt_vld;

   dtc_code_buf #(
      .W (CW)
   ) u_code_buf (
      .dco_clk  (dco_clk),
      .reset    (reset),
      .push_vld (buf_push),
      .push_rdy (code_ready),
      .push_dat (code),
      .pop      (buf_pop),
      .q_vld    (nxt_vld),
      .q_dat    (nxt_dat)
   );

   always_ff @(posedge dco_clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         act_dat  <= '0;
         edge_out <= 1'b0;
         fine_sel <= '0;
         busy     <= 1'b0;
         overrun  <= 1'b0;
         miss     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (code_acc) begin
                  act_dat <= code;
                  state   <= ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (trig) begin
                  cnt  <= act_coarse;
                  busy <= 1'b1;
                  if (act_coarse == '0) begin
                     state    <= ST_FIRE;
                     edge_out <= 1'b1;
                     fine_sel <= act_fine;
                  end else begin
                     state <= ST_COUNT;
                  end
               end
            end
            ST_COUNT: begin
               // Countdown stops at 1, so the counter can never wrap.
               if (cnt > COARSE_W'(1)) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  state    <= ST_FIRE;
                  edge_out <= 1'b1;
                  fine_sel <= act_fine;
               end
            end
            ST_FIRE: begin
               edge_out <= 1'b0;
               fine_sel <= '0;
               busy     <= 1'b0;
               if (nxt_vld) begin
                  act_dat <= nxt_dat;
                  state   <= ST_ARMED;
               end else if (code_acc) begin
                  act_dat <= code;
                  state   <= ST_ARMED;
               end else begin
`ifdef DTC_AUTORELOAD_EN
                  state <= ST_ARMED;
`else
                  state <= ST_IDLE;
`endif
               end
            end
            default: state <= ST_IDLE;
         endcase

         // Clear first so a same-cycle set takes priority.
         if (err_clr) begin
            overrun <= 1'b0;
            miss    <= 1'b0;
         end
         if (trig && ((state == ST_COUNT) || (state == ST_FIRE))) overrun <= 1'b1;
         if (trig && (state == ST_IDLE)) miss <= 1'b1;
      end
   end
endmodule

// File: tb/tb_dtc_edge_gen.sv
// Self-checking bench for dtc_edge_gen: directed scenarios plus randomized traffic against a timing model.
module tb_dtc_edge_gen;
   import dtc_pkg::*;

`ifdef DTC_AUTORELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic              dco_clk = 1'b0;
   logic              reset;
   logic [CODE_W-1:0] code;
   logic              code_valid;
   logic              code_ready;
   logic              trig;
   logic              edge_out;
   logic [1:0]        fine_sel;
   logic              busy;
   logic              overrun;
   logic              miss;
   logic              err_clr;

   int errors;
   int checks;

   dtc_edge_gen #(
      .COARSE_W (8),
      .FINE_W   (2)
   ) dut (
      .dco_clk    (dco_clk),
      .reset      (reset),
      .code       (code),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .trig       (trig),
      .edge_out   (edge_out),
      .fine_sel   (fine_sel),
      .busy       (busy),
      .overrun    (overrun),
      .miss       (miss),
      .err_clr    (err_clr)
   );

   always #5 dco_clk = ~dco_clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

   // Drive one cycle of inputs; returns at the next falling edge with outputs settled.
   task automatic drive(input int tr, input int cv, input int cd, input int ec);
      trig       = (tr != 0);
      code_valid = (cv != 0);
      code       = cd[CODE_W-1:0];
      err_clr    = (ec != 0);
      @(negedge dco_clk);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      reset = 1'b0;
      drive(0, 0, 0, 0);
   endtask

   // Trig once, then watch maxc cycles: first edge offset, pulse count, fine_sel at edge, stray fine_sel.
   task automatic trig_measure(input int maxc, output int lat, output int np,
                               output logic [1:0] fs, output int bad);
      drive(1, 0, 0, 0);
      lat = -1; np = 0; fs = '0; bad = 0;
      for (int i = 1; i <= maxc; i++) begin
         if (edge_out) begin
            np++;
            if (lat < 0) begin lat = i; fs = fine_sel; end
         end else if (fine_sel !== 2'd0) begin
            bad++;
         end
         if (i < maxc) drive(0, 0, 0, 0);
      end
   endtask

   // Reference model: time-stamped fire schedule plus a code queue.
   bit   m_have, m_pend, m_ovr, m_miss;
   int   m_act, m_fire, m_cyc;
   int   m_next[$];

   task automatic model_reset();
      m_have = 0; m_pend = 0; m_ovr = 0; m_miss = 0;
      m_act = 0; m_fire = 0; m_cyc = 0;
      m_next.delete();
   endtask

   task automatic model_step(input bit rst, input bit tr, input bit cv, input int cd, input bit ec);
      bit acc, firing;
      if (rst) begin
         model_reset();
         return;
      end
      acc    = cv && (m_next.size() == 0);
      firing = m_pend && (m_cyc == m_fire);
      if (ec) begin m_ovr = 0; m_miss = 0; end
      if (tr) begin
         if (!m_have) m_miss = 1;
         else if (m_pend) m_ovr = 1;
         else begin
            m_pend = 1;
            m_fire = m_cyc + (cd - cd) + (m_act / 4) + 1;
         end
      end
      if (firing) begin
         m_pend = 0;
         if (m_next.size() != 0) m_act = m_next.pop_front();
         else if (acc) m_act = cd;
         else if (!AUTO) m_have = 0;
      end else if (acc) begin
         if (!m_have) begin m_act = cd; m_have = 1; end
         else m_next.push_back(cd);
      end
      m_cyc++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(0, 1, 10'h3FF, 0);
      drive(1, 1, 10'h3FF, 0);
      reset = 1'b0;
      drive(0, 0, 0, 0);
      checks++;
      if ({edge_out, busy, overrun, miss, code_ready} !== 5'b00001) begin
         errors++;
         $display("FAIL reset_outputs: got edge/busy/ovr/miss/rdy=%b want 00001",
                  {edge_out, busy, overrun, miss, code_ready});
      end
      checks++;
      if (fine_sel !== 2'd0) begin
         errors++; $display("FAIL reset_fine_sel: got %0d want 0", fine_sel);
      end
      // A code offered during reset must not have armed the block.
      drive(1, 0, 0, 0);
      checks++;
      if ({miss, busy} !== 2'b10) begin
         errors++; $display("FAIL reset_code_ignored: got miss,busy=%b want 10", {miss, busy});
      end
   endtask

   task automatic test_basic();
      int lat, np, bad;
      logic [1:0] fs;
      logic [1:0] exp_mb;
      apply_reset();
      drive(0, 1, 10'h008, 0);
      trig_measure(6, lat, np, fs, bad);
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL basic_latency: got %0d want 3", lat); end
      checks++;
      if ({np, bad} !== {32'd1, 32'd0}) begin
         errors++; $display("FAIL basic_pulses: got pulses=%0d stray_fine=%0d want 1,0", np, bad);
      end
      checks++;
      if (fs !== 2'd0) begin errors++; $display("FAIL basic_fine: got %0d want 0", fs); end
      drive(1, 0, 0, 0);
      exp_mb = AUTO ? 2'b01 : 2'b10;
      checks++;
      if ({miss, busy} !== exp_mb) begin
         errors++; $display("FAIL basic_after_fire: got miss,busy=%b want %b", {miss, busy}, exp_mb);
      end
   endtask

   task automatic test_fine0();
      int lat, np, bad;
      logic [1:0] fs;
      apply_reset();
      drive(0, 1, 10'h003, 0);
      trig_measure(4, lat, np, fs, bad);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL fine0_latency: got %0d want 1", lat); end
      checks++;
      if (fs !== 2'd3) begin errors++; $display("FAIL fine0_fine: got %0d want 3", fs); end
      checks++;
      if ({np, bad} !== {32'd1, 32'd0}) begin
         errors++; $display("FAIL fine0_pulses: got pulses=%0d stray_fine=%0d want 1,0", np, bad);
      end
   endtask

   task automatic test_overrun();
      int lat, np, bad, edge_at, npulse;
      logic [1:0] fs, efs;
      apply_reset();
      drive(0, 1, 10'h015, 0);
      drive(1, 0, 0, 0);
      drive(0, 1, 10'h006, 0);
      checks++;
      if (code_ready !== 1'b0) begin errors++; $display("FAIL ovr_queue_full: got rdy=%b want 0", code_ready); end
      drive(1, 0, 0, 0);
      checks++;
      if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
      edge_at = -1; npulse = 0; efs = '0;
      for (int k = 4; k <= 9; k++) begin
         drive(0, 0, 0, 0);
         if (edge_out) begin
            npulse++;
            if (edge_at < 0) begin edge_at = k; efs = fine_sel; end
         end
      end
      checks++;
      if ({edge_at, npulse} !== {32'd6, 32'd1}) begin
         errors++; $display("FAIL ovr_edge: got at=%0d pulses=%0d want 6,1", edge_at, npulse);
      end
      checks++;
      if (efs !== 2'd1) begin errors++; $display("FAIL ovr_fine: got %0d want 1", efs); end
      checks++;
      if ({code_ready, busy} !== 2'b10) begin
         errors++; $display("FAIL ovr_rearmed: got rdy,busy=%b want 10", {code_ready, busy});
      end
      trig_measure(4, lat, np, fs, bad);
      checks++;
      if ({lat, 30'd0, fs} !== {32'd2, 30'd0, 2'd2}) begin
         errors++; $display("FAIL ovr_second_edge: got lat=%0d fine=%0d want 2,2", lat, fs);
      end
      checks++;
      if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
   endtask

   task automatic test_miss();
      int lat, np, bad;
      logic [1:0] fs;
      apply_reset();
      drive(1, 0, 0, 0);
      checks++;
      if ({miss, edge_out, busy} !== 3'b100) begin
         errors++; $display("FAIL miss_set: got miss,edge,busy=%b want 100", {miss, edge_out, busy});
      end
      drive(0, 0, 0, 1);
      checks++;
      if (miss !== 1'b0) begin errors++; $display("FAIL miss_clear: got %b want 0", miss); end
      drive(1, 0, 0, 1);
      checks++;
      if (miss !== 1'b1) begin errors++; $display("FAIL miss_set_wins: got %b want 1", miss); end
      drive(0, 0, 0, 1);
      drive(1, 1, 10'h00C, 0);
      checks++;
      if ({miss, busy, code_ready} !== 3'b101) begin
         errors++; $display("FAIL miss_accept_trig: got miss,busy,rdy=%b want 101", {miss, busy, code_ready});
      end
      trig_measure(5, lat, np, fs, bad);
      checks++;
      if ({lat, np} !== {32'd4, 32'd1}) begin
         errors++; $display("FAIL miss_armed_edge: got lat=%0d pulses=%0d want 4,1", lat, np);
      end
   endtask

   task automatic test_queue_full();
      int lat, np, bad, ready_at, edge_at;
      logic [1:0] fs;
      apply_reset();
      drive(0, 1, 10'h011, 0);
      drive(0, 1, 10'h00A, 0);
      checks++;
      if (code_ready !== 1'b0) begin errors++; $display("FAIL qf_ready_low: got %b want 0", code_ready); end
      drive(1, 1, 10'h003, 0);
      ready_at = -1; edge_at = -1;
      for (int i = 1; i <= 8; i++) begin
         if (code_ready && ready_at < 0) ready_at = i;
         if (edge_out && edge_at < 0) edge_at = i;
         drive(0, (ready_at < 0 || ready_at == i) ? 1 : 0, 10'h003, 0);
      end
      checks++;
      if ({edge_at, ready_at} !== {32'd5, 32'd6}) begin
         errors++; $display("FAIL qf_holdoff: got edge_at=%0d ready_at=%0d want 5,6", edge_at, ready_at);
      end
      checks++;
      if (code_ready !== 1'b0) begin errors++; $display("FAIL qf_third_queued: got rdy=%b want 0", code_ready); end
      trig_measure(4, lat, np, fs, bad);
      checks++;
      if ({lat, 30'd0, fs} !== {32'd3, 30'd0, 2'd2}) begin
         errors++; $display("FAIL qf_second_code: got lat=%0d fine=%0d want 3,2", lat, fs);
      end
      trig_measure(3, lat, np, fs, bad);
      checks++;
      if ({lat, 30'd0, fs} !== {32'd1, 30'd0, 2'd3}) begin
         errors++; $display("FAIL qf_third_code: got lat=%0d fine=%0d want 1,3", lat, fs);
      end
   endtask

   task automatic test_reset_mid();
      int np;
      apply_reset();
      drive(0, 1, 10'h320, 0);
      drive(1, 0, 0, 0);
      drive(0, 0, 0, 0);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL rm_counting: got busy=%b want 1", busy); end
      reset = 1'b1;
      drive(0, 1, 10'h0FF, 0);
      drive(0, 1, 10'h0FF, 0);
      reset = 1'b0;
      drive(0, 0, 0, 0);
      checks++;
      if ({edge_out, fine_sel, busy, overrun, miss, code_ready} !== 7'b0000001) begin
         errors++; $display("FAIL rm_outputs: got %b want 0000001",
                            {edge_out, fine_sel, busy, overrun, miss, code_ready});
      end
      np = 0;
      for (int i = 0; i < 220; i++) begin
         if (edge_out) np++;
         drive(0, 0, 0, 0);
      end
      checks++;
      if (np !== 0) begin errors++; $display("FAIL rm_no_edge: got %0d pulses want 0", np); end
      drive(1, 0, 0, 0);
      checks++;
      if ({miss, busy} !== 2'b10) begin
         errors++; $display("FAIL rm_idle: got miss,busy=%b want 10", {miss, busy});
      end
   endtask

   task automatic test_autoreload();
      int lat[3], np[3], exp_lat[3], exp_np[3], bad;
      logic [1:0] fs;
      logic exp_miss;
      apply_reset();
      drive(0, 1, 10'h01D, 0);
      for (int k = 0; k < 3; k++) trig_measure(20, lat[k], np[k], fs, bad);
      exp_lat  = AUTO ? '{8, 8, 8} : '{8, -1, -1};
      exp_np   = AUTO ? '{1, 1, 1} : '{1, 0, 0};
      exp_miss = !AUTO;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({lat[k], np[k]} !== {exp_lat[k], exp_np[k]}) begin
            errors++; $display("FAIL reload_trig%0d: got lat=%0d pulses=%0d want %0d,%0d",
                               k, lat[k], np[k], exp_lat[k], exp_np[k]);
         end
      end
      checks++;
      if (miss !== exp_miss) begin errors++; $display("FAIL reload_miss: got %b want %b", miss, exp_miss); end
   endtask

   task automatic test_random();
      bit r, tr, cv, ec, prev_rst, e_edge;
      int cd;
      logic [1:0] e_fine;
      logic [6:0] exp_v, got_v;
      apply_reset();
      model_reset();
      prev_rst = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         e_edge = m_pend && (m_cyc == m_fire);
         e_fine = e_edge ? 2'(m_act % 4) : 2'd0;
         exp_v  = {e_edge, e_fine, m_pend, m_ovr, m_miss, m_next.size() == 0};
         got_v  = {edge_out, fine_sel, busy, overrun, miss, code_ready};
         if (!prev_rst) begin
            checks++;
            if (got_v !== exp_v) begin
               errors++; $display("FAIL random_cycle%0d: got edge/fine/busy/ovr/miss/rdy=%b want %b",
                                  c, got_v, exp_v);
            end
         end
         r  = ($urandom_range(0, 299) == 0);
         tr = ($urandom_range(0, 6) == 0);
         cv = ($urandom_range(0, 2) == 0);
         ec = ($urandom_range(0, 15) == 0);
         cd = (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 6))) * 4
              + int'($urandom_range(0, 3));
         reset = r;
         model_step(r, tr, cv, cd, ec);
         prev_rst = r;
         drive(tr, cv, cd, ec);
      end
      reset = 1'b0;
   endtask

   initial begin
      errors = 0; checks = 0;
      reset = 1'b1; trig = 1'b0; code_valid = 1'b0; code = '0; err_clr = 1'b0;
      test_reset();
      test_basic();
      test_fine0();
      test_overrun();
      test_miss();
      test_queue_full();
      test_reset_mid();
      test_autoreload();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
